// File: rtl/rsa_seq_pkg.sv
// Shared encodings for the RSA command sequencer: opcodes, error codes,
// FSM states, command layout and status word packing.
package rsa_seq_pkg;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_LOADM = 4'd3;
    localparam logic [3:0] OP_NOP   = 4'd4;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_OPCODE = 3'd1;
    localparam logic [2:0] ERR_SLOT   = 3'd2;
    localparam logic [2:0] ERR_NO_M   = 3'd3;

    localparam int ST_ERR_BIT  = 0;
    localparam int ST_CODE_LSB = 1;
    localparam int ST_OP_LSB   = 4;
    localparam int ST_CYC_LSB  = 8;
    localparam int CYC_W       = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_LOAD,
        S_LOADM,
        S_COMPUTE,
        S_STORE,
        S_RESPOND
    } state_t;

    typedef struct packed {
        logic [3:0] src_b;
        logic [3:0] src_a;
        logic [3:0] dst;
        logic [3:0] opcode;
    } cmd_t;

    function automatic logic [31:0] pack_status(
        input logic [2:0]       code,
        input logic [3:0]       op,
        input logic [CYC_W-1:0] cyc
    );
        logic [31:0] s;
        s = '0;
        s[ST_ERR_BIT] = (code != ERR_NONE);
        s[ST_CODE_LSB +: 3] = code;
        s[ST_OP_LSB +: 4] = op;
        s[ST_CYC_LSB +: CYC_W] = cyc;
        return s;
    endfunction

endpackage

// File: rtl/rsa_operand_bank.sv
// Operand slot register file: one write port, three combinational read
// ports (multiplier a, multiplier b, store path), cleared by reset.
module rsa_operand_bank
    import rsa_seq_pkg::*;
#(
    parameter  int RSA_BITS  = 1024,
    parameter  int NUM_SLOTS = 4,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [SLOT_W-1:0]   waddr,
    input  logic [RSA_BITS-1:0] wdata,
    input  logic [SLOT_W-1:0]   raddr_a,
    input  logic [SLOT_W-1:0]   raddr_b,
    input  logic [SLOT_W-1:0]   raddr_s,
    output logic [RSA_BITS-1:0] rdata_a,
    output logic [RSA_BITS-1:0] rdata_b,
    output logic [RSA_BITS-1:0] rdata_s
);

    localparam logic [SLOT_W:0] NSLOT = (SLOT_W+1)'(NUM_SLOTS);

    logic [RSA_BITS-1:0] slots [NUM_SLOTS];

    // Non-power-of-two banks leave index codes with no backing slot.
    function automatic logic in_bank(input logic [SLOT_W-1:0] idx);
        return {1'b0, idx} < NSLOT;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else if (we && in_bank(waddr)) begin
            slots[waddr] <= wdata;
        end
    end

    assign rdata_a = in_bank(raddr_a) ? slots[raddr_a] : '0;
    assign rdata_b = in_bank(raddr_b) ? slots[raddr_b] : '0;
    assign rdata_s = in_bank(raddr_s) ? slots[raddr_s] : '0;

endmodule

// File: rtl/rsa_cmd_sequencer.sv
// Command-driven Montgomery front end with operand slots and status word.
// Optional RSA_SEQ_CYCLE_COUNT_EN reports MULT cycle count in status.
module rsa_cmd_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int RSA_BITS  = 1024,
    parameter int NUM_SLOTS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RSA_BITS-1:0] bram_din,
    input  logic                bram_din_valid,
    output logic [RSA_BITS-1:0] bram_dout,
    output logic                bram_dout_valid,
    input  logic                bram_dout_read,
    input  logic [31:0]         port1_din,
    input  logic                port1_valid,
    output logic                port1_read,
    output logic [31:0]         port2_dout,
    output logic                port2_valid,
    input  logic                port2_read,
    output logic [RSA_BITS-1:0] core_a,
    output logic [RSA_BITS-1:0] core_b,
    output logic [RSA_BITS-1:0] core_m,
    output logic                core_start,
    input  logic [RSA_BITS-1:0] core_result,
    input  logic                core_done
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam logic [4:0] NSLOT = 5'(NUM_SLOTS);

    state_t              state;
    cmd_t                cmd;
    logic [2:0]          err;
    logic                m_valid;
    logic [RSA_BITS-1:0] m_reg;
    logic [2:0]          dec_err;
    state_t              exec_state;
    logic                bad_op;
    logic                bad_slot;
    logic                no_m;
    logic                bank_we;
    logic [RSA_BITS-1:0] bank_wdata;
    logic [CYC_W-1:0]    cyc_rep;
    logic                unused_hi;

    assign unused_hi = ^port1_din[31:16];

    function automatic logic slot_ok(input logic [3:0] f);
        return {1'b0, f} < NSLOT;
    endfunction

    always_comb begin
        bad_slot = 1'b0;
        unique case (cmd.opcode)
            OP_LOAD:  bad_slot = !slot_ok(cmd.dst);
            OP_MULT:  bad_slot = !slot_ok(cmd.dst) || !slot_ok(cmd.src_a)
                                 || !slot_ok(cmd.src_b);
            OP_STORE: bad_slot = !slot_ok(cmd.src_a);
            default:  bad_slot = 1'b0;
        endcase
    end

    // Conditions are made disjoint so the one-hot decode holds.
    assign bad_op = cmd.opcode > OP_NOP;
    assign no_m   = (cmd.opcode == OP_MULT) && !m_valid && !bad_slot;

    always_comb begin
        dec_err = ERR_NONE;
        unique case (1'b1)
            bad_op:   dec_err = ERR_OPCODE;
            bad_slot: dec_err = ERR_SLOT;
            no_m:     dec_err = ERR_NO_M;
            default:  dec_err = ERR_NONE;
        endcase
    end

    always_comb begin
        exec_state = S_RESPOND;
        unique case (cmd.opcode)
            OP_LOAD:  exec_state = S_LOAD;
            OP_MULT:  exec_state = S_COMPUTE;
            OP_STORE: exec_state = S_STORE;
            OP_LOADM: exec_state = S_LOADM;
            default:  exec_state = S_RESPOND;
        endcase
    end

    assign bank_we = (state == S_LOAD && bram_din_valid)
                     || (state == S_COMPUTE && core_done);
    assign bank_wdata = (state == S_COMPUTE) ? core_result : bram_din;
    assign core_m = m_reg;

    rsa_operand_bank #(
        .RSA_BITS  (RSA_BITS),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (bank_we),
        .waddr   (cmd.dst[SLOT_W-1:0]),
        .wdata   (bank_wdata),
        .raddr_a (cmd.src_a[SLOT_W-1:0]),
        .raddr_b (cmd.src_b[SLOT_W-1:0]),
        .raddr_s (cmd.src_a[SLOT_W-1:0]),
        .rdata_a (core_a),
        .rdata_b (core_b),
        .rdata_s (bram_dout)
    );

`ifdef RSA_SEQ_CYCLE_COUNT_EN
    logic [CYC_W-1:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
        end else if (state == S_DECODE && dec_err == ERR_NONE
                     && exec_state == S_COMPUTE) begin
            cyc_cnt <= '0;
        end else if (state == S_COMPUTE && cyc_cnt != '1) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    assign cyc_rep = (cmd.opcode == OP_MULT && err == ERR_NONE)
                     ? cyc_cnt : '0;
`else
    assign cyc_rep = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cmd             <= '0;
            err             <= ERR_NONE;
            m_valid         <= 1'b0;
            m_reg           <= '0;
            port1_read      <= 1'b0;
            port2_valid     <= 1'b0;
            port2_dout      <= '0;
            bram_dout_valid <= 1'b0;
            core_start      <= 1'b0;
        end else begin
            port1_read <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (port1_valid) begin
                        cmd        <= port1_din[15:0];
                        port1_read <= 1'b1;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    err <= dec_err;
                    if (dec_err != ERR_NONE) begin
                        state <= S_RESPOND;
                    end else begin
                        state           <= exec_state;
                        core_start      <= (exec_state == S_COMPUTE);
                        bram_dout_valid <= (exec_state == S_STORE);
                    end
                end
                S_LOAD: begin
                    if (bram_din_valid) state <= S_RESPOND;
                end
                S_LOADM: begin
                    if (bram_din_valid) begin
                        m_reg   <= bram_din;
                        m_valid <= 1'b1;
                        state   <= S_RESPOND;
                    end
                end
                S_COMPUTE: begin
                    if (core_done) begin
                        core_start <= 1'b0;
                        state      <= S_RESPOND;
                    end
                end
                S_STORE: begin
                    if (bram_dout_read) begin
                        bram_dout_valid <= 1'b0;
                        state           <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (!port2_valid) begin
                        port2_valid <= 1'b1;
                        port2_dout  <= pack_status(err, cmd.opcode, cyc_rep);
                    end else if (port2_read) begin
                        port2_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_cmd_sequencer.sv
// Directed bench for rsa_cmd_sequencer with an 8-bit datapath, M = 97.
// Multiplier stub returns a*b*R^-1 mod 97 (R = 256, R^-1 = 36).
module tb_rsa_cmd_sequencer;

    localparam int RB = 8;
    localparam int NS = 4;

`ifdef RSA_SEQ_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [RB-1:0] bram_din = '0;
    logic          bram_din_valid = 1'b0;
    logic [RB-1:0] bram_dout;
    logic          bram_dout_valid;
    logic          bram_dout_read = 1'b0;
    logic [31:0]   port1_din = '0;
    logic          port1_valid = 1'b0;
    logic          port1_read;
    logic [31:0]   port2_dout;
    logic          port2_valid;
    logic          port2_read = 1'b0;
    logic [RB-1:0] core_a;
    logic [RB-1:0] core_b;
    logic [RB-1:0] core_m;
    logic          core_start;
    logic [RB-1:0] core_result = '0;
    logic          core_done = 1'b0;

    rsa_cmd_sequencer #(
        .RSA_BITS  (RB),
        .NUM_SLOTS (NS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bram_din        (bram_din),
        .bram_din_valid  (bram_din_valid),
        .bram_dout       (bram_dout),
        .bram_dout_valid (bram_dout_valid),
        .bram_dout_read  (bram_dout_read),
        .port1_din       (port1_din),
        .port1_valid     (port1_valid),
        .port1_read      (port1_read),
        .port2_dout      (port2_dout),
        .port2_valid     (port2_valid),
        .port2_read      (port2_read),
        .core_a          (core_a),
        .core_b          (core_b),
        .core_m          (core_m),
        .core_start      (core_start),
        .core_result     (core_result),
        .core_done       (core_done)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned tick = 0;
    int unsigned t_cmd = 0;
    int unsigned t_stat = 0;
    int          done_lat = 5;
    int          start_cnt = 0;
    bit          saw_start = 1'b0;
    logic [RB-1:0] exp_a = '0;
    logic [RB-1:0] exp_b = '0;
    logic [31:0] st;

    always @(posedge clk) tick <= tick + 1;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Multiplier stub: done pulses in the done_lat-th cycle of core_start.
    always @(negedge clk) begin
        if (core_start) begin
            saw_start = 1'b1;
            start_cnt = start_cnt + 1;
            if (start_cnt == done_lat) begin
                check_eq("core_a", 32'(core_a), 32'(exp_a));
                check_eq("core_b", 32'(core_b), 32'(exp_b));
                check_eq("core_m", 32'(core_m), 32'h61);
                core_result = 8'((int'(core_a) * int'(core_b) * 36) % 97);
                core_done = 1'b1;
            end else begin
                core_done = 1'b0;
            end
        end else begin
            start_cnt = 0;
            core_done = 1'b0;
        end
    end

    task automatic send_cmd(input logic [31:0] w);
        bit got;
        got = 1'b0;
        @(negedge clk);
        port1_din = w;
        port1_valid = 1'b1;
        t_cmd = tick;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = port1_read;
        end
        port1_valid = 1'b0;
        check_eq("port1_read", 32'(got), 32'd1);
    endtask

    task automatic get_status(output logic [31:0] s);
        int n;
        n = 0;
        while (!port2_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("port2_valid", 32'(port2_valid), 32'd1);
        s = port2_dout;
        t_stat = tick;
        port2_read = 1'b1;
        @(negedge clk);
        port2_read = 1'b0;
        check_eq("port2_release", 32'(port2_valid), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] w, input logic [RB-1:0] d,
                           input logic [31:0] exp_st, input string tag);
        send_cmd(w);
        @(negedge clk);
        bram_din = d;
        bram_din_valid = 1'b1;
        @(negedge clk);
        bram_din_valid = 1'b0;
        get_status(st);
        check_eq(tag, st, exp_st);
    endtask

    task automatic do_mult(input logic [31:0] w, input int lat,
                           input logic [RB-1:0] ea, input logic [RB-1:0] eb,
                           input logic [31:0] exp_st, input string tag);
        done_lat = lat;
        exp_a = ea;
        exp_b = eb;
        send_cmd(w);
        get_status(st);
        check_eq(tag, st, exp_st);
    endtask

    task automatic do_store(input logic [3:0] slot, input int hold,
                            input logic [RB-1:0] exp_d, input string tag);
        int n;
        int held;
        send_cmd({20'd0, slot, 4'd0, 4'h2});
        n = 0;
        while (!bram_dout_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(bram_dout_valid), 32'd1);
        check_eq(tag, 32'(bram_dout), 32'(exp_d));
        held = 0;
        for (int i = 0; i < hold; i++) begin
            if (bram_dout_valid && bram_dout == exp_d) held++;
            @(negedge clk);
        end
        check_eq({tag, "_held"}, 32'(held), 32'(hold));
        bram_dout_read = 1'b1;
        @(negedge clk);
        bram_dout_read = 1'b0;
        check_eq({tag, "_release"}, 32'(bram_dout_valid), 32'd0);
        get_status(st);
        check_eq({tag, "_status"}, st, 32'h20);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ctl"}, {28'd0, port1_read, port2_valid,
                 bram_dout_valid, core_start}, 32'd0);
        check_eq({tag, "_p2dout"}, port2_dout, 32'd0);
        check_eq({tag, "_dout"}, 32'(bram_dout), 32'd0);
        check_eq({tag, "_core"}, {8'd0, core_a, core_b, core_m}, 32'd0);
    endtask

    function automatic logic [31:0] mult_ok(input int cyc);
        return CNT_EN ? {24'(cyc), 8'h10} : 32'h10;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        send_cmd(32'hABCD_0004);
        check_eq("port1_pulse", 32'(port1_read), 32'd1);
        @(negedge clk);
        check_eq("port1_once", 32'(port1_read), 32'd0);
        get_status(st);
        check_eq("nop_status", st, 32'h40);
        check_eq("nop_latency", t_stat - t_cmd + 1, 32'd4);

        saw_start = 1'b0;
        send_cmd(32'h1021);
        get_status(st);
        check_eq("mult_no_m", st, 32'h17);
        check_eq("no_core_start", 32'(saw_start), 32'd0);

        do_load(32'h0003, 8'h61, 32'h30, "load_m");
        do_load(32'h0000, 8'h05, 32'h00, "load_s0");
        do_load(32'h0010, 8'h07, 32'h00, "load_s1");
        do_mult(32'h1021, 37, 8'h05, 8'h07, mult_ok(37), "mult_2_0_1");

        send_cmd(32'h000F);
        get_status(st);
        check_eq("bad_opcode", st, 32'hF3);
        do_load(32'h0050, 8'hAA, 32'h05, "bad_slot");

        do_store(4'd2, 10, 8'h60, "store_s2");
        do_store(4'd1, 0, 8'h07, "store_s1");

        do_mult(32'h0001, 5, 8'h05, 8'h05, mult_ok(5), "mult_alias");
        do_store(4'd0, 2, 8'h1B, "store_s0");

        done_lat = 1000;
        send_cmd(32'h2131);
        begin
            int n;
            n = 0;
            while (!core_start && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("abort_started", 32'(core_start), 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("abort");
        repeat (5) @(negedge clk);
        check_eq("abort_quiet", {30'd0, port2_valid, core_start}, 32'd0);
        do_store(4'd0, 0, 8'h00, "cleared_s0");
        do_store(4'd3, 0, 8'h00, "cleared_s3");
        saw_start = 1'b0;
        send_cmd(32'h1021);
        get_status(st);
        check_eq("m_cleared", st, 32'h17);
        check_eq("m_cleared_start", 32'(saw_start), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
